hazard_detection_unit: RTL and testbench

Stall/flush controller for the 5-stage 32-bit pipeline; it is the counterpart of operand forwarding. It detects the hazards forwarding cannot cover: load-use, branch operands needed in ID, and data-memory wait. It drives the PC, IF/ID, ID/EX and later-stage register enables, keeps saturating stall/flush statistics and flags a stuck data-memory access.

---
 rtl/hazard_detection_unit.sv | 107 ++++++++++
 tb/tb_hazard_detection_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-operand and
// data-memory-wait hazards, with saturating statistics and a dmem watchdog.
module hazard_detection_unit #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_reg_rs,
   input  logic [4:0]       ID_reg_rt,
   input  logic             ID_uses_rt,
   input  logic             ID_branch,
   input  logic             branch_taken,
   input  logic [4:0]       ID_EX_reg_rd,
   input  logic             ID_EX_regWrite,
   input  logic             ID_EX_memRead,
   input  logic [4:0]       EX_MEM_reg_rd,
   input  logic             EX_MEM_memRead,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             ID_EX_bubble,
   output logic             IF_ID_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout,
   output logic [1:0]       hz_state
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      DATA_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_t;

   hz_state_t         state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              ex_match, mem_match;
   logic              load_use, br_alu, br_load;
   logic              data_stall, freeze;

   always_comb begin
      ex_match  = (ID_EX_reg_rd != '0) &&
                  ((ID_EX_reg_rd == ID_reg_rs) || (ID_uses_rt && (ID_EX_reg_rd == ID_reg_rt)));
      mem_match = (EX_MEM_reg_rd != '0) &&
                  ((EX_MEM_reg_rd == ID_reg_rs) || (ID_uses_rt && (EX_MEM_reg_rd == ID_reg_rt)));
      load_use   = ID_EX_memRead && ex_match;
      br_alu     = ID_branch && ID_EX_regWrite && !ID_EX_memRead && ex_match;
      br_load    = ID_branch && EX_MEM_memRead && mem_match;
      data_stall = load_use || br_alu || br_load;
      freeze     = dmem_busy;
   end

   // Reset forces a bubble with everything else disabled, independent of the inputs.
   always_comb begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b0;
      IF_ID_flush  = 1'b0;
      pipe_hold    = 1'b0;
      if (!rst_n) begin
         ID_EX_bubble = 1'b1;
      end else if (freeze) begin
         pipe_hold = 1'b1;
      end else if (data_stall) begin
         ID_EX_bubble = 1'b1;
      end else begin
         pc_write    = 1'b1;
         IF_ID_write = 1'b1;
         IF_ID_flush = ID_branch && branch_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         stall_count <= '0;
         flush_count <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (freeze)          state <= MEM_WAIT;
         else if (data_stall) state <= DATA_STALL;
         else                 state <= RUN;

         if (data_stall && !freeze && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if (IF_ID_flush && (flush_count != '1))
            flush_count <= flush_count + 1'b1;

         if (dmem_busy) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT))
               wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign hz_state = state;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios followed by
// random stimulus, all compared against a rule-level reference model.
module tb_hazard_detection_unit;

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned MAX_WAIT = 4;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       ID_reg_rs, ID_reg_rt, ID_EX_reg_rd, EX_MEM_reg_rd;
   logic             ID_uses_rt, ID_branch, branch_taken;
   logic             ID_EX_regWrite, ID_EX_memRead, EX_MEM_memRead, dmem_busy;
   logic             pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic             mem_timeout;
   logic [1:0]       hz_state;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int m_stall, m_flush, m_busy_run, m_state;
   bit m_to;

   hazard_detection_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_reg_rs(ID_reg_rs), .ID_reg_rt(ID_reg_rt), .ID_uses_rt(ID_uses_rt),
      .ID_branch(ID_branch), .branch_taken(branch_taken),
      .ID_EX_reg_rd(ID_EX_reg_rd), .ID_EX_regWrite(ID_EX_regWrite),
      .ID_EX_memRead(ID_EX_memRead), .EX_MEM_reg_rd(EX_MEM_reg_rd),
      .EX_MEM_memRead(EX_MEM_memRead), .dmem_busy(dmem_busy),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
      .IF_ID_flush(IF_ID_flush), .pipe_hold(pipe_hold),
      .stall_count(stall_count), .flush_count(flush_count),
      .mem_timeout(mem_timeout), .hz_state(hz_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A producer blocks the ID instruction if it writes a register ID reads.
   function automatic bit needs(input logic [4:0] rd);
      if (rd == 5'd0) return 1'b0;
      return (rd == ID_reg_rs) || (ID_uses_rt && rd == ID_reg_rt);
   endfunction

   function automatic bit exp_stall();
      bit from_load_ex   = ID_EX_memRead && needs(ID_EX_reg_rd);
      bit branch_on_alu  = ID_branch && ID_EX_regWrite && !ID_EX_memRead && needs(ID_EX_reg_rd);
      bit branch_on_load = ID_branch && EX_MEM_memRead && needs(EX_MEM_reg_rd);
      return from_load_ex || branch_on_alu || branch_on_load;
   endfunction

   task automatic model_reset();
      m_stall = 0; m_flush = 0; m_busy_run = 0; m_state = 0; m_to = 0;
   endtask

   task automatic check_comb();
      bit pw, iw, bub, fl, hold;
      if (!rst_n)         begin pw = 0; iw = 0; bub = 1; fl = 0; hold = 0; end
      else if (dmem_busy) begin pw = 0; iw = 0; bub = 0; fl = 0; hold = 1; end
      else if (exp_stall()) begin pw = 0; iw = 0; bub = 1; fl = 0; hold = 0; end
      else begin pw = 1; iw = 1; bub = 0; fl = ID_branch && branch_taken; hold = 0; end
      chk("pc_write",     32'(pc_write),     32'(pw));
      chk("IF_ID_write",  32'(IF_ID_write),  32'(iw));
      chk("ID_EX_bubble", 32'(ID_EX_bubble), 32'(bub));
      chk("IF_ID_flush",  32'(IF_ID_flush),  32'(fl));
      chk("pipe_hold",    32'(pipe_hold),    32'(hold));
   endtask

   task automatic check_regs();
      chk("stall_count", 32'(stall_count), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
      chk("hz_state",    32'(hz_state),    32'(m_state));
   endtask

   // One cycle: check combinational outputs, advance the model, clock, check registers.
   task automatic step();
      bit st;
      #1;
      check_comb();
      st = exp_stall();
      if (!rst_n) model_reset();
      else begin
         m_state = dmem_busy ? 2 : (st ? 1 : 0);
         if (!dmem_busy && st && m_stall < CNT_MAX) m_stall++;
         if (!dmem_busy && !st && ID_branch && branch_taken && m_flush < CNT_MAX) m_flush++;
         if (dmem_busy) begin
            m_busy_run++;
            if (m_busy_run >= MAX_WAIT) m_to = 1;
         end else m_busy_run = 0;
      end
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic tk,
                         input logic [4:0] exrd, input logic exw, input logic exmr,
                         input logic [4:0] memrd, input logic memmr, input logic busy);
      ID_reg_rs = rs; ID_reg_rt = rt; ID_uses_rt = urt;
      ID_branch = br; branch_taken = tk;
      ID_EX_reg_rd = exrd; ID_EX_regWrite = exw; ID_EX_memRead = exmr;
      EX_MEM_reg_rd = memrd; EX_MEM_memRead = memmr; dmem_busy = busy;
   endtask

   task automatic idle();
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      // Reset with a live hazard on the inputs still gives reset outputs.
      set_in(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
      step();
      step();
      rst_n = 1'b1;

      // Load-use
      set_in(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      step();
      chk("loaduse_state", 32'(hz_state), 32'd1);
      chk("loaduse_stalls", 32'(stall_count), 32'd1);
      idle(); step();

      // Load feeding a branch: load_use then br_load, then the taken branch flushes
      set_in(5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      step();
      set_in(5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      step();
      chk("brload_stalls_sat", 32'(stall_count), 32'd3);
      set_in(5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      chk("branch_flush_cnt", 32'(flush_count), 32'd1);
      idle(); step();

      // ALU result feeding a branch, and register zero never stalls
      set_in(5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      step();

      // Freeze takes priority over load-use
      set_in(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
      step();
      chk("freeze_state", 32'(hz_state), 32'd2);

      // Watchdog: 3 busy (1 already done above + 2), idle, then 4 busy
      idle(); dmem_busy = 1'b1; step(); step();
      idle(); step();
      chk("wd_no_timeout", 32'(mem_timeout), 32'd0);
      dmem_busy = 1'b1; step(); step(); step();
      chk("wd_before_4th", 32'(mem_timeout), 32'd0);
      step();
      chk("wd_after_4th", 32'(mem_timeout), 32'd1);
      idle(); step();

      // Asynchronous reset mid-wait
      dmem_busy = 1'b1; step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_comb();
      check_regs();
      step();
      #2 rst_n = 1'b1;

      // Five load-use stalls saturate at 3
      for (int i = 0; i < 5; i++) begin
         set_in(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
         step();
      end
      chk("stall_saturate", 32'(stall_count), 32'd3);
      idle(); step();

      // Random traffic with a small register space to force matches
      #2 rst_n = 1'b0; model_reset(); #1; check_regs();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), ($urandom % 4) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
